// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// gv_input_pkg
//
// Purpose : Shared types and defaults for the fret-button input front end.
//           This package is imported by the lane debouncer, the top-level
//           conditioner and the bus interface, so every file uses the same
//           state encoding and the same default configuration.
//
// Contents: btn_state_t         per-lane debounce FSM state
//           GV_DEFAULT_DEBOUNCE  default number of stable samples per commit
//           GV_DEFAULT_LANES     default number of button lanes
//           state_level()        debounced level implied by an FSM state
// ---------------------------------------------------------------------------
package gv_input_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } btn_state_t;

  // Simulation-friendly default. Board builds override this with roughly
  // 1 ms worth of clocks.
  localparam int unsigned GV_DEFAULT_DEBOUNCE = 4;

  // Lane 0 feeds the game core's button_1 input, lane 1 feeds button_2.
  localparam int GV_DEFAULT_LANES = 2;

  // The committed level is still the old one while a change is pending, so
  // the pending states report the level of the state they came from.
  function automatic logic state_level(btn_state_t s);
    return (s == PRESSED) || (s == RELEASE_PENDING);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//
// Purpose : Bundles the button pins, the pulse-enable control and the
//           conditioned outputs into one connection.
//
// Signals : raw_btn     [NUM_LANES]  asynchronous button pins, active-high
//           enable                   gates press/release pulses
//           btn_level   [NUM_LANES]  debounced level per lane
//           btn_press   [NUM_LANES]  one-cycle pulse on committed 0->1
//           btn_release [NUM_LANES]  one-cycle pulse on committed 1->0
//           any_press                OR of btn_press
//
// Modports: master - the board/pin side, drives raw_btn and enable
//           slave  - the conditioner, drives the conditioned outputs
// ---------------------------------------------------------------------------
interface button_conditioner_if
  import gv_input_pkg::*;
#(
  parameter int NUM_LANES = GV_DEFAULT_LANES
);

  logic [NUM_LANES-1:0] raw_btn;
  logic                 enable;
  logic [NUM_LANES-1:0] btn_level;
  logic [NUM_LANES-1:0] btn_press;
  logic [NUM_LANES-1:0] btn_release;
  logic                 any_press;

  modport master (
    output raw_btn,
    output enable,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  any_press
  );

  modport slave (
    input  raw_btn,
    input  enable,
    output btn_level,
    output btn_press,
    output btn_release,
    output any_press
  );

endinterface

// File: rtl/button_conditioner_lane_debouncer.sv
// ---------------------------------------------------------------------------
// lane_debouncer
//
// Purpose : Conditions one raw button pin. The pin first goes through a
//           two-flop synchronizer. A four-state FSM then commits a level
//           change only after DEBOUNCE_CYCLES consecutive synchronized
//           samples disagree with the current level. Registered press and
//           release pulses mark each committed change.
//
// Ports   : clk        system clock, rising edge
//           rst        synchronous active-high reset
//           raw_i      asynchronous button pin, active-high
//           enable_i   when low, the pulse for a commit on this edge is
//                      dropped; the level still follows the FSM
//           level_o    debounced level (registered)
//           press_o    one-cycle pulse after a committed 0->1 change
//           release_o  one-cycle pulse after a committed 1->0 change
// ---------------------------------------------------------------------------
module lane_debouncer
  import gv_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = GV_DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic enable_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // cnt holds the number of disagreeing samples already accepted. The
  // incoming sample commits the change when it is the DEBOUNCE_CYCLES-th
  // one, so the comparison is against DEBOUNCE_CYCLES-1. The counter never
  // goes past that value, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // With a single-sample debounce, the first disagreeing sample commits at
  // once and the pending states are never entered.
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

  logic             sync0_q;
  logic             sync1_q;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;
  logic             commit_press;
  logic             commit_release;

  // Two-flop synchronizer. The FSM looks only at sync1_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= raw_i;
      sync1_q <= sync0_q;
    end
  end

  // State register, together with the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    commit_press   = 1'b0;
    commit_release = 1'b0;

    case (state_q)
      RELEASED: begin
        if (sync1_q) begin
          if (SINGLE_SAMPLE) begin
            state_d      = PRESSED;
            cnt_d        = '0;
            commit_press = 1'b1;
          end else begin
            state_d = PRESS_PENDING;
            cnt_d   = CNT_ONE;
          end
        end
      end

      PRESS_PENDING: begin
        if (!sync1_q) begin
          // A bounce back to the old level throws the partial count away.
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = PRESSED;
          cnt_d        = '0;
          commit_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!sync1_q) begin
          if (SINGLE_SAMPLE) begin
            state_d        = RELEASED;
            cnt_d          = '0;
            commit_release = 1'b1;
          end else begin
            state_d = RELEASE_PENDING;
            cnt_d   = CNT_ONE;
          end
        end
      end

      RELEASE_PENDING: begin
        if (sync1_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = RELEASED;
          cnt_d          = '0;
          commit_release = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. Pulses are gated by enable as seen on the commit edge; a
  // commit while disabled is simply lost, never deferred.
  always_comb begin
    level_d   = state_level(state_d);
    press_d   = commit_press & enable_i;
    release_d = commit_release & enable_i;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Purpose : Input front end for the game core. Each button lane gets its own
//           lane_debouncer; lanes never interact. The press pulses of all
//           lanes are ORed into any_press.
//
// Ports   : clk  system clock, rising edge
//           rst  synchronous active-high reset, has priority over all inputs
//           bus  button_conditioner_if.slave
//                  in : raw_btn[NUM_LANES], enable
//                  out: btn_level, btn_press, btn_release [NUM_LANES],
//                       any_press
//
// Params  : NUM_LANES        number of button lanes (must match the bus)
//           DEBOUNCE_CYCLES  stable synchronized samples per commit,
//                            legal range 1..65535
// ---------------------------------------------------------------------------
module button_conditioner
  import gv_input_pkg::*;
#(
  parameter int          NUM_LANES       = GV_DEFAULT_LANES,
  parameter int unsigned DEBOUNCE_CYCLES = GV_DEFAULT_DEBOUNCE
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [NUM_LANES-1:0] level_w;
  logic [NUM_LANES-1:0] press_w;
  logic [NUM_LANES-1:0] release_w;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      lane_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .raw_i     (bus.raw_btn[gi]),
        .enable_i  (bus.enable),
        .level_o   (level_w[gi]),
        .press_o   (press_w[gi]),
        .release_o (release_w[gi])
      );
    end
  endgenerate

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;

  // Combinational OR of registered pulses: any_press lines up with the lane
  // pulses and is 0 out of reset because they are.
  assign bus.any_press   = |press_w;

endmodule
